vga_out_pipe: RTL and testbench
===============================

VGA_OUT_PIPE -- requirements
Module: vga_out_pipe

Interface
REQ-001 SHALL have parameter R_W, default 5: red output width, 1..8.
REQ-002 SHALL have parameter G_W, default 6: green output width, 1..8.
REQ-003 SHALL have parameter B_W, default 5: blue output width, 1..8.
REQ-004 SHALL have parameter DEPTH, default 2: output pipeline stages, 1..4.
REQ-005 SHALL have parameter ROUND, default 0: 0 truncates, 1 rounds half-up with saturation.
REQ-006 SHALL have parameter HS_POL, default 1: asserted level of hsync.
REQ-007 SHALL have parameter VS_POL, default 1: asserted level of vsync.
REQ-008 SHALL have parameter BAR_SHIFT, default 4: log2 of test-bar width in pixels.
REQ-009 SHALL use one clock, clk; reset rst is asynchronous and active-high.
REQ-010 SHALL have ports:
- clk  in  1  pixel clock.
- rst  in  1  async active-high reset.
- vsync_i  in  1  input vertical sync.
- hsync_i  in  1  input horizontal sync.
- valid  in  1  pixel valid (active video).
- rgb_i  in  24  pixel as {R8,G8,B8}.
- mode  in  2  0 pass, 1 colour bars, 2 solid, 3 black.
- solid_rgb  in  24  solid colour for mode 2.
- vsync_o  out  1  delayed vsync.
- hsync_o  out  1  delayed hsync.
- r  out  R_W  red.
- g  out  G_W  green.
- b  out  B_W  blue.
- frame_cnt  out  16  vsync assertions since reset.
- line_px  out  12  valid pixels in last complete line.

Function
REQ-011 SHALL delay vsync_o, hsync_o, r, g and b by exactly DEPTH clk cycles relative to their inputs, all aligned.
REQ-012 SHALL output r=g=b=0 for any cycle whose valid was 0, in every mode.
REQ-013 SHALL, with ROUND=0, take each channel's top N bits: r=R8[7:8-R_W]; g and b likewise.
REQ-014 SHALL, with ROUND=1, output min(floor((C8 + 2^(7-N)) / 2^(8-N)), 2^N-1) per channel; N=8 passes unchanged.
REQ-015 SHALL detect a vsync assertion edge as vsync_i going from !VS_POL to VS_POL on consecutive cycles; hsync assertion edges are detected likewise with HS_POL.
REQ-016 SHALL keep an active-mode register loaded from mode only in the cycle of a vsync assertion edge, so a mode change takes effect on a frame boundary.
REQ-017 SHALL keep a 12-bit pixel counter x: it is set to 0 on an hsync assertion edge and otherwise increments on valid=1, saturating at 4095.
REQ-018 SHALL, when an hsync assertion edge and valid=1 coincide, latch line_px from the old x and count that pixel as x=0 of the new line (x becomes 1).
REQ-019 SHALL, in mode 1, form bar k=(x>>BAR_SHIFT) mod 8, colour index c=7-k, with R8=c[2]?FF:00, G8=c[1]?FF:00, B8=c[0]?FF:00, using the pre-increment x of that cycle.
REQ-020 SHALL, in mode 2, use solid_rgb sampled in the same cycle as valid; in mode 3, output black.
REQ-021 SHALL increment frame_cnt by 1 on each vsync assertion edge, wrapping 65535->0.
REQ-022 SHALL update line_px on each hsync assertion edge only, one cycle after the edge.

Reset
REQ-023 SHALL, while rst=1, drive r, g, b, frame_cnt, line_px, x and the active mode to 0, and all pipeline stages to 0.
REQ-024 SHALL drive the sync pipeline, vsync_o and hsync_o to deasserted levels (!VS_POL, !HS_POL) during reset; the edge detectors reset to the deasserted level.
REQ-025 SHALL, after reset mid-frame, produce no spurious edge; the first edge counts only after sync is seen deasserted then asserted.

Structure
REQ-026 SHALL place the mode encodings (PASS, BARS, SOLID, BLACK) and the bar colour table in shared package vga_pkg.
REQ-027 SHALL implement channel truncation/rounding in a sub-module vga_chan_quant, instantiated three times.

Verification
REQ-028 Default params, mode 0, valid=1, rgb_i=24'hFF8040 -> after 2 cycles r=5'h1F, g=6'h20, b=5'h08.
REQ-029 ROUND=1, rgb_i=24'hFC0000, R_W=5 -> r=5'h1F (saturated); rgb_i=24'h0C0000 -> r=5'h02.
REQ-030 Mode set to 1 mid-frame -> output stays pass-through until next vsync assertion edge; then pixels 0..15 are white, 16..31 yellow {1F,3F,00}, and 128 is white again.
REQ-031 Line of 640 valid pixels, hsync edge coincident with valid -> line_px=640 and the coincident pixel is bar 0.
REQ-032 valid=0 with rgb_i=24'hFFFFFF -> r=g=b=0; syncs are still delayed by DEPTH=2.
REQ-033 rst pulsed mid-line with VS_POL=1 and vsync_i held 1 -> frame_cnt=0 and stays 0 until vsync_i falls and rises again, then becomes 1.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the VGA output pipe.
//   mode_e   : source-select encodings for the pixel stream.
//   BAR_RGB  : colour-bar table indexed by the 3-bit colour index {R,G,B}.
//   X_MAX    : saturation value of the 12-bit pixel counter.
package vga_pkg;

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      BARS  = 2'd1,
      SOLID = 2'd2,
      BLACK = 2'd3
   } mode_e;

   // Entry i is {i[2]?FF:00, i[1]?FF:00, i[0]?FF:00}.
   localparam logic [23:0] BAR_RGB [0:7] = '{
      24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
      24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF
   };

   localparam logic [11:0] X_MAX = 12'hFFF;

   // Bars run white first, so bar k shows colour 7-k.
   function automatic logic [2:0] bar_colour_index(input logic [2:0] k);
      return 3'd7 - k;
   endfunction

endpackage

// File: rtl/vga_out_pipe_if.sv
// vga_out_pipe_if -- video stream in, quantised video stream out.
//   Inputs : vsync_i, hsync_i, valid, rgb_i[23:0], mode[1:0], solid_rgb[23:0]
//   Outputs: vsync_o, hsync_o, r[R_W-1:0], g[G_W-1:0], b[B_W-1:0],
//            frame_cnt[15:0], line_px[11:0]
// Handshake: valid qualifies rgb_i in the cycle it is high; there is no
// ready, the sink always accepts one pixel per clock and never stalls.
// master drives the source side, slave is the pipe itself.
interface vga_out_pipe_if #(
   parameter int R_W = 5,
   parameter int G_W = 6,
   parameter int B_W = 5
);
   logic           vsync_i;
   logic           hsync_i;
   logic           valid;
   logic [23:0]    rgb_i;
   logic [1:0]     mode;
   logic [23:0]    solid_rgb;
   logic           vsync_o;
   logic           hsync_o;
   logic [R_W-1:0] r;
   logic [G_W-1:0] g;
   logic [B_W-1:0] b;
   logic [15:0]    frame_cnt;
   logic [11:0]    line_px;

   modport master (
      output vsync_i, hsync_i, valid, rgb_i, mode, solid_rgb,
      input  vsync_o, hsync_o, r, g, b, frame_cnt, line_px
   );

   modport slave (
      input  vsync_i, hsync_i, valid, rgb_i, mode, solid_rgb,
      output vsync_o, hsync_o, r, g, b, frame_cnt, line_px
   );
endinterface

// File: rtl/vga_chan_quant.sv
// vga_chan_quant -- reduce one 8-bit colour channel to N bits.
//   c : 8-bit channel in
//   q : N-bit channel out; ROUND=0 keeps the top N bits, ROUND=1 rounds
//       half-up and saturates at 2^N-1.
module vga_chan_quant #(
   parameter int N     = 5,
   parameter int ROUND = 0
) (
   input  logic [7:0]   c,
   output logic [N-1:0] q
);

   generate
      if (ROUND == 0) begin : g_trunc
         assign q = c[7:8-N];
      end else begin : g_round
         // Half an output LSB; zero when N=8 so the channel passes through.
         localparam int         HALF = 128 >> N;
         localparam int         SH   = 8 - N;
         localparam logic [8:0] MAXV = 9'((1 << N) - 1);

         logic [8:0] sum;
         logic [8:0] shifted;

         assign sum     = {1'b0, c} + 9'(HALF);
         assign shifted = sum >> SH;
         assign q       = (shifted > MAXV) ? MAXV[N-1:0] : shifted[N-1:0];
      end
   endgenerate

endmodule

// File: rtl/vga_out_pipe.sv
// vga_out_pipe -- VGA output stage: source select, colour quantisation and
// a DEPTH-stage delay keeping syncs and colour aligned.
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : vga_out_pipe_if slave (sync/pixel in, sync/colour out,
//              frame_cnt = vsync assertions, line_px = pixels in last line)
module vga_out_pipe
   import vga_pkg::*;
#(
   parameter int   R_W       = 5,
   parameter int   G_W       = 6,
   parameter int   B_W       = 5,
   parameter int   DEPTH     = 2,
   parameter int   ROUND     = 0,
   parameter logic HS_POL    = 1'b1,
   parameter logic VS_POL    = 1'b1,
   parameter int   BAR_SHIFT = 4
) (
   input logic           clk,
   input logic           rst,
   vga_out_pipe_if.slave bus
);

   // Sync edge detection. The arm flags stay low after reset until the sync
   // has been seen deasserted, so a sync held asserted across reset does
   // not produce an edge.
   logic vs_q, hs_q;
   logic vs_arm, hs_arm;
   logic vs_edge, hs_edge;

   assign vs_edge = vs_arm && (bus.vsync_i == VS_POL) && (vs_q != VS_POL);
   assign hs_edge = hs_arm && (bus.hsync_i == HS_POL) && (hs_q != HS_POL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_q   <= ~VS_POL;
         hs_q   <= ~HS_POL;
         vs_arm <= 1'b0;
         hs_arm <= 1'b0;
      end else begin
         vs_q <= bus.vsync_i;
         hs_q <= bus.hsync_i;
         if (bus.vsync_i != VS_POL) vs_arm <= 1'b1;
         if (bus.hsync_i != HS_POL) hs_arm <= 1'b1;
      end
   end

   // Frame/line state: active mode only changes on a frame boundary.
   mode_e       act_mode;
   logic [15:0] frame_cnt;
   logic [11:0] x;
   logic [11:0] line_px;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_mode  <= PASS;
         frame_cnt <= '0;
         x         <= '0;
         line_px   <= '0;
      end else begin
         if (vs_edge) begin
            act_mode  <= mode_e'(bus.mode);
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (hs_edge) begin
            line_px <= x;
            // A pixel coincident with the edge is x=0 of the new line.
            x <= bus.valid ? 12'd1 : 12'd0;
         end else if (bus.valid && (x != X_MAX)) begin
            x <= x + 12'd1;
         end
      end
   end

   assign bus.frame_cnt = frame_cnt;
   assign bus.line_px   = line_px;

   // Source select, using the pre-increment position of this pixel.
   logic [11:0] px_x;
   logic [2:0]  bar_k;
   logic [23:0] pix;

   assign px_x  = hs_edge ? 12'd0 : x;
   assign bar_k = 3'(px_x >> BAR_SHIFT);

   always_comb begin
      pix = 24'h000000;
      if (bus.valid) begin
         case (act_mode)
            PASS:    pix = bus.rgb_i;
            BARS:    pix = BAR_RGB[bar_colour_index(bar_k)];
            SOLID:   pix = bus.solid_rgb;
            BLACK:   pix = 24'h000000;
            default: pix = 24'h000000;
         endcase
      end
   end

   logic [R_W-1:0] r_q;
   logic [G_W-1:0] g_q;
   logic [B_W-1:0] b_q;

   vga_chan_quant #(.N(R_W), .ROUND(ROUND)) u_quant_r (.c(pix[23:16]), .q(r_q));
   vga_chan_quant #(.N(G_W), .ROUND(ROUND)) u_quant_g (.c(pix[15:8]),  .q(g_q));
   vga_chan_quant #(.N(B_W), .ROUND(ROUND)) u_quant_b (.c(pix[7:0]),   .q(b_q));

   // Output delay line; stage DEPTH-1 drives the ports.
   logic [R_W-1:0] r_p  [DEPTH];
   logic [G_W-1:0] g_p  [DEPTH];
   logic [B_W-1:0] b_p  [DEPTH];
   logic           vs_p [DEPTH];
   logic           hs_p [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_p[i]  <= '0;
            g_p[i]  <= '0;
            b_p[i]  <= '0;
            vs_p[i] <= ~VS_POL;
            hs_p[i] <= ~HS_POL;
         end
      end else begin
         r_p[0]  <= r_q;
         g_p[0]  <= g_q;
         b_p[0]  <= b_q;
         vs_p[0] <= bus.vsync_i;
         hs_p[0] <= bus.hsync_i;
         for (int i = 1; i < DEPTH; i++) begin
            r_p[i]  <= r_p[i-1];
            g_p[i]  <= g_p[i-1];
            b_p[i]  <= b_p[i-1];
            vs_p[i] <= vs_p[i-1];
            hs_p[i] <= hs_p[i-1];
         end
      end
   end

   assign bus.r       = r_p[DEPTH-1];
   assign bus.g       = g_p[DEPTH-1];
   assign bus.b       = b_p[DEPTH-1];
   assign bus.vsync_o = vs_p[DEPTH-1];
   assign bus.hsync_o = hs_p[DEPTH-1];

endmodule

// File: tb/tb_vga_out_pipe.sv
// tb_vga_out_pipe -- directed bench for vga_out_pipe. Two instances share
// the stimulus: dut_t (defaults, truncating) and dut_r (ROUND=1). A
// frame-level model predicts every output cycle; literal checks pin it.
module tb_vga_out_pipe;
   localparam int DEPTH = 2;

   logic clk;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   vga_out_pipe_if #(.R_W(5), .G_W(6), .B_W(5)) bus ();
   vga_out_pipe_if #(.R_W(5), .G_W(6), .B_W(5)) bus2 ();

   assign bus2.vsync_i   = bus.vsync_i;
   assign bus2.hsync_i   = bus.hsync_i;
   assign bus2.valid     = bus.valid;
   assign bus2.rgb_i     = bus.rgb_i;
   assign bus2.mode      = bus.mode;
   assign bus2.solid_rgb = bus.solid_rgb;

   vga_out_pipe #(.ROUND(0)) dut_t (.clk(clk), .rst(rst), .bus(bus));
   vga_out_pipe #(.ROUND(1)) dut_r (.clk(clk), .rst(rst), .bus(bus2));

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   // exp word: {vs, hs, r, g, b (trunc), vs, hs, r, g, b (round)}
   logic [35:0] exp_q[$];
   int m_prev_vs, m_prev_hs;   // -1 = no sample since reset
   int m_mode, m_x, m_line, m_frame;

   function automatic int quant(input int c, input int n, input int rnd);
      int v;
      if (rnd == 0) return c >> (8 - n);
      v = (c + (128 >> n)) >> (8 - n);
      if (v > (1 << n) - 1) v = (1 << n) - 1;
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_prev_vs = -1; m_prev_hs = -1;
         m_mode = 0; m_x = 0; m_line = 0; m_frame = 0;
         exp_q.delete();
      end else begin
         bit v_edge, h_edge;
         int px, pr, pg, pb, cidx;
         v_edge = (bus.vsync_i == 1'b1) && (m_prev_vs == 0);
         h_edge = (bus.hsync_i == 1'b1) && (m_prev_hs == 0);
         px = h_edge ? 0 : m_x;
         pr = 0; pg = 0; pb = 0;
         if (bus.valid) begin
            if (m_mode == 0) begin
               pr = int'(bus.rgb_i[23:16]); pg = int'(bus.rgb_i[15:8]); pb = int'(bus.rgb_i[7:0]);
            end else if (m_mode == 1) begin
               cidx = 7 - ((px / 16) % 8);
               pr = (cidx & 4) ? 255 : 0; pg = (cidx & 2) ? 255 : 0; pb = (cidx & 1) ? 255 : 0;
            end else if (m_mode == 2) begin
               pr = int'(bus.solid_rgb[23:16]); pg = int'(bus.solid_rgb[15:8]); pb = int'(bus.solid_rgb[7:0]);
            end
         end
         exp_q.push_back({bus.vsync_i, bus.hsync_i,
                          5'(quant(pr, 5, 0)), 6'(quant(pg, 6, 0)), 5'(quant(pb, 5, 0)),
                          bus.vsync_i, bus.hsync_i,
                          5'(quant(pr, 5, 1)), 6'(quant(pg, 6, 1)), 5'(quant(pb, 5, 1))});
         if (v_edge) begin
            m_frame = (m_frame + 1) % 65536;
            m_mode  = int'(bus.mode);
         end
         if (h_edge) begin
            m_line = m_x;
            m_x    = bus.valid ? 1 : 0;
         end else if (bus.valid && m_x < 4095) begin
            m_x = m_x + 1;
         end
         m_prev_vs = bus.vsync_i ? 1 : 0;
         m_prev_hs = bus.hsync_i ? 1 : 0;
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         logic [35:0] e, a;
         if (exp_q.size() >= DEPTH) begin
            e = exp_q.pop_front();
            a = {bus.vsync_o, bus.hsync_o, bus.r, bus.g, bus.b,
                 bus2.vsync_o, bus2.hsync_o, bus2.r, bus2.g, bus2.b};
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL stream @%0t: got %h expected %h", $time, a, e);
            end
         end
         n_tests++;
         if (bus.frame_cnt !== 16'(m_frame) || bus.line_px !== 12'(m_line) ||
             bus2.frame_cnt !== 16'(m_frame) || bus2.line_px !== 12'(m_line)) begin
            n_fail++;
            $display("FAIL counters @%0t: got frame %0d/%0d line %0d/%0d expected frame %0d line %0d",
                     $time, bus.frame_cnt, bus2.frame_cnt, bus.line_px, bus2.line_px, m_frame, m_line);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic vs, input logic hs, input logic vld, input logic [23:0] rgb);
      bus.vsync_i = vs;
      bus.hsync_i = hs;
      bus.valid   = vld;
      bus.rgb_i   = rgb;
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_rgb(input string name, input logic [4:0] er, input logic [5:0] eg, input logic [4:0] eb);
      chk({name, ".r"}, 32'(bus.r), 32'(er));
      chk({name, ".g"}, 32'(bus.g), 32'(eg));
      chk({name, ".b"}, 32'(bus.b), 32'(eb));
   endtask

   task automatic new_frame(input logic [1:0] m);
      bus.mode = m;
      drive(1'b1, 1'b0, 1'b0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst           = 1'b1;
      bus.vsync_i   = 1'b0;
      bus.hsync_i   = 1'b0;
      bus.valid     = 1'b0;
      bus.rgb_i     = 24'h0;
      bus.mode      = 2'd0;
      bus.solid_rgb = 24'h0;
      repeat (3) drive(1'b0, 1'b0, 1'b0, 24'h0);

      // Reset state
      chk_rgb("reset", 5'h00, 6'h00, 5'h00);
      chk("reset.vsync_o", 32'(bus.vsync_o), 32'h0);
      chk("reset.hsync_o", 32'(bus.hsync_o), 32'h0);
      chk("reset.frame_cnt", 32'(bus.frame_cnt), 32'h0);
      chk("reset.line_px", 32'(bus.line_px), 32'h0);
      rst = 1'b0;
      repeat (3) drive(1'b0, 1'b0, 1'b0, 24'h0);

      // Pass-through truncation and rounding
      drive(1'b0, 1'b0, 1'b1, 24'hFF8040);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      chk_rgb("pass_ff8040", 5'h1F, 6'h20, 5'h08);
      drive(1'b0, 1'b0, 1'b1, 24'hFC0000);
      drive(1'b0, 1'b0, 1'b1, 24'h0C0000);
      chk("round_fc.r", 32'(bus2.r), 32'h1F);
      chk("trunc_fc.r", 32'(bus.r), 32'h1F);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      chk("round_0c.r", 32'(bus2.r), 32'h02);
      chk("trunc_0c.r", 32'(bus.r), 32'h01);

      // Blanked pixel with hsync: colour zero, sync delayed exactly DEPTH
      drive(1'b0, 1'b1, 1'b0, 24'hFFFFFF);
      chk("hs_not_early", 32'(bus.hsync_o), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 24'hFFFFFF);
      chk("hs_delay2", 32'(bus.hsync_o), 32'h1);
      chk_rgb("blank", 5'h00, 6'h00, 5'h00);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      chk("hs_release", 32'(bus.hsync_o), 32'h0);
      chk("line_px_3", 32'(bus.line_px), 32'd3);

      // Mode 1 requested mid-frame: still pass-through
      bus.mode = 2'd1;
      drive(1'b0, 1'b0, 1'b1, 24'h123456);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      chk_rgb("mode_pending", 5'h02, 6'h0D, 5'h0A);

      // Frame boundary activates bars; 640-pixel line starting on hsync
      new_frame(2'd1);
      for (int i = 0; i < 640; i++) begin
         drive(1'b0, (i == 0), 1'b1, 24'($urandom_range(0, 24'hFFFFFF)));
         if (i == 1)   chk_rgb("bar_px0", 5'h1F, 6'h3F, 5'h1F);
         if (i == 17)  chk_rgb("bar_px16", 5'h1F, 6'h3F, 5'h00);
         if (i == 129) chk_rgb("bar_px128", 5'h1F, 6'h3F, 5'h1F);
      end
      drive(1'b0, 1'b1, 1'b1, 24'h0);
      drive(1'b0, 1'b0, 1'b1, 24'h0);
      chk("line_px_640", 32'(bus.line_px), 32'd640);
      chk_rgb("coincident_bar0", 5'h1F, 6'h3F, 5'h1F);
      repeat (3) drive(1'b0, 1'b0, 1'b0, 24'h0);

      // Solid colour
      bus.solid_rgb = 24'h00FF00;
      new_frame(2'd2);
      drive(1'b0, 1'b0, 1'b1, 24'hFF00FF);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      chk_rgb("solid", 5'h00, 6'h3F, 5'h00);

      // Black
      new_frame(2'd3);
      drive(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      chk_rgb("black", 5'h00, 6'h00, 5'h00);
      chk("frame_cnt_3", 32'(bus.frame_cnt), 32'd3);

      // Reset mid-line with vsync held asserted
      drive(1'b0, 1'b0, 1'b1, 24'h808080);
      drive(1'b1, 1'b0, 1'b1, 24'h808080);
      drive(1'b1, 1'b0, 1'b1, 24'h808080);
      chk("frame_cnt_4", 32'(bus.frame_cnt), 32'd4);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("rst_mid.frame_cnt", 32'(bus.frame_cnt), 32'h0);
      chk("rst_mid.vsync_o", 32'(bus.vsync_o), 32'h0);
      chk_rgb("rst_mid", 5'h00, 6'h00, 5'h00);
      rst = 1'b0;
      repeat (5) drive(1'b1, 1'b0, 1'b1, 24'h404040);
      chk("no_spurious_edge", 32'(bus.frame_cnt), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      chk("still_zero", 32'(bus.frame_cnt), 32'h0);
      drive(1'b1, 1'b0, 1'b0, 24'h0);
      chk("first_real_edge", 32'(bus.frame_cnt), 32'h1);
      repeat (4) drive(1'b0, 1'b0, 1'b0, 24'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
